// File: rtl/smi_mem_test_pkg.sv
// ---------------------------------------------------------------------------
// smi_mem_test_pkg
// Shared types and default widths for the SMI memory test sources/checkers.
//   state_t        : sequencer FSM states
//   DEF_*_WIDTH    : default parameter values for the test blocks
// ---------------------------------------------------------------------------
package smi_mem_test_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_LEN_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SET_PARAMS = 3'd1,
        ST_WRITE_DATA = 3'd2,
        ST_GET_STATUS = 3'd3,
        ST_REPORT     = 3'd4
    } state_t;

endpackage

// File: rtl/smi_mem_test_pattern_gen.sv
// ---------------------------------------------------------------------------
// smi_mem_test_pattern_gen
// Counting-sequence register shared by the write source and read checker.
//   clk       : clock
//   i_load    : capture i_init as current value and i_incr as step
//   i_init    : first word of the sequence
//   i_incr    : increment applied per advance
//   i_advance : step the sequence by the captured increment (mod 2^W)
//   o_value   : current sequence word
// The register is deliberately not reset; it is always loaded before use.
// ---------------------------------------------------------------------------
module smi_mem_test_pattern_gen #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_init,
    input  logic [DATA_WIDTH-1:0] i_incr,
    input  logic                  i_advance,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic [DATA_WIDTH-1:0] r_value;
    logic [DATA_WIDTH-1:0] r_incr;

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_value <= i_init;
            r_incr  <= i_incr;
        end else if (i_advance) begin
            r_value <= r_value + r_incr;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/smi_mem_write_burst_sequencer.sv
// ---------------------------------------------------------------------------
// smi_mem_write_burst_sequencer
// Turns one test request into a sequence of write bursts at a fixed address
// stride, streams a counting data pattern that continues across bursts, and
// aggregates per-burst status into one test result.
// Ports:
//   clk, srst                 : clock, synchronous active-high reset
//   testParams*               : test request in (valid/stop)
//   testDone*                 : test result out (valid/stop)
//   writeParam*               : burst request to the write controller
//   writeData*                : write data stream to the controller
//   writeDone*                : per-burst status from the controller
//   o_dbg_state               : current FSM state
// Handshake: on every channel a transfer happens in a cycle where valid=1 and
// stop=0; valid never depends combinationally on stop.
// ---------------------------------------------------------------------------
module smi_mem_write_burst_sequencer
    import smi_mem_test_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  testParamsValid,
    input  logic [ADDR_WIDTH-1:0] testParamBurstAddr,
    input  logic [LEN_WIDTH-1:0]  testParamBurstLen,
    input  logic [CNT_WIDTH-1:0]  testParamBurstCount,
    input  logic [ADDR_WIDTH-1:0] testParamAddrStride,
    input  logic [7:0]            testParamBurstOpts,
    input  logic [DATA_WIDTH-1:0] testParamDataInit,
    input  logic [DATA_WIDTH-1:0] testParamDataIncr,
    output logic                  testParamsStop,
    output logic                  testDoneValid,
    output logic                  testDoneStatusOk,
    output logic [CNT_WIDTH-1:0]  testDoneErrorCount,
    input  logic                  testDoneStop,
    output logic                  writeParamsValid,
    output logic [ADDR_WIDTH-1:0] writeParamBurstAddr,
    output logic [LEN_WIDTH-1:0]  writeParamBurstLen,
    output logic [7:0]            writeParamBurstOpts,
    input  logic                  writeParamsStop,
    output logic                  writeDataValid,
    output logic [DATA_WIDTH-1:0] writeDataValue,
    input  logic                  writeDataStop,
    input  logic                  writeDoneValid,
    input  logic                  writeDoneStatusOk,
    output logic                  writeDoneStop,
    output logic [2:0]            o_dbg_state
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [7:0]            r_opts;
    logic [CNT_WIDTH-1:0]  r_bursts_left;
    logic [LEN_WIDTH-1:0]  r_words_left;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic                  r_all_ok;

    logic                  w_req_xfer;
    logic                  w_data_xfer;
    logic [DATA_WIDTH-1:0] w_pattern;

    assign w_req_xfer  = !srst && (r_state == ST_IDLE) && testParamsValid;
    assign w_data_xfer = !srst && (r_state == ST_WRITE_DATA) && !writeDataStop;

    smi_mem_test_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern_gen (
        .clk       (clk),
        .i_load    (w_req_xfer),
        .i_init    (testParamDataInit),
        .i_incr    (testParamDataIncr),
        .i_advance (w_data_xfer),
        .o_value   (w_pattern)
    );

    // Only the state is reset; datapath registers are always reloaded on the
    // request transfer before they are observed.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (testParamsValid) begin
                        r_addr        <= testParamBurstAddr;
                        r_stride      <= testParamAddrStride;
                        r_len         <= testParamBurstLen;
                        r_opts        <= testParamBurstOpts;
                        r_bursts_left <= testParamBurstCount;
                        r_words_left  <= testParamBurstLen;
                        r_err_cnt     <= '0;
                        r_all_ok      <= 1'b1;
                        // Degenerate requests report success with no bursts.
                        if (testParamBurstCount == '0 || testParamBurstLen == '0)
                            r_state <= ST_REPORT;
                        else
                            r_state <= ST_SET_PARAMS;
                    end
                end
                ST_SET_PARAMS: begin
                    if (!writeParamsStop)
                        r_state <= ST_WRITE_DATA;
                end
                ST_WRITE_DATA: begin
                    if (!writeDataStop) begin
                        r_words_left <= r_words_left - LEN_WIDTH'(1);
                        if (r_words_left == LEN_WIDTH'(1))
                            r_state <= ST_GET_STATUS;
                    end
                end
                ST_GET_STATUS: begin
                    if (writeDoneValid) begin
                        if (!writeDoneStatusOk) begin
                            r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
                            r_all_ok  <= 1'b0;
                        end
                        r_bursts_left <= r_bursts_left - CNT_WIDTH'(1);
                        r_addr        <= r_addr + r_stride;
                        r_words_left  <= r_len;
                        if (r_bursts_left == CNT_WIDTH'(1))
                            r_state <= ST_REPORT;
                        else
                            r_state <= ST_SET_PARAMS;
                    end
                end
                ST_REPORT: begin
                    if (!testDoneStop)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign testParamsStop      = (r_state != ST_IDLE);
    assign writeParamsValid    = (r_state == ST_SET_PARAMS);
    assign writeParamBurstAddr = r_addr;
    assign writeParamBurstLen  = r_len;
    assign writeParamBurstOpts = r_opts;
    assign writeDataValid      = (r_state == ST_WRITE_DATA);
    assign writeDataValue      = w_pattern;
    assign writeDoneStop       = (r_state != ST_GET_STATUS);
    assign testDoneValid       = (r_state == ST_REPORT);
    assign testDoneStatusOk    = r_all_ok;
    assign testDoneErrorCount  = r_err_cnt;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_smi_mem_write_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_smi_mem_write_burst_sequencer
// Directed scenarios for the write burst sequencer. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_smi_mem_write_burst_sequencer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          srst;
    logic          testParamsValid;
    logic [AW-1:0] testParamBurstAddr;
    logic [LW-1:0] testParamBurstLen;
    logic [CW-1:0] testParamBurstCount;
    logic [AW-1:0] testParamAddrStride;
    logic [7:0]    testParamBurstOpts;
    logic [DW-1:0] testParamDataInit;
    logic [DW-1:0] testParamDataIncr;
    logic          testParamsStop;
    logic          testDoneValid;
    logic          testDoneStatusOk;
    logic [CW-1:0] testDoneErrorCount;
    logic          testDoneStop;
    logic          writeParamsValid;
    logic [AW-1:0] writeParamBurstAddr;
    logic [LW-1:0] writeParamBurstLen;
    logic [7:0]    writeParamBurstOpts;
    logic          writeParamsStop;
    logic          writeDataValid;
    logic [DW-1:0] writeDataValue;
    logic          writeDataStop;
    logic          writeDoneValid;
    logic          writeDoneStatusOk;
    logic          writeDoneStop;
    logic [2:0]    o_dbg_state;

    int tests_run = 0;
    int fail_cnt  = 0;

    // Observed transactions and results of the last run_seq call
    logic [AW-1:0] obs_addr_q[$];
    logic [LW-1:0] obs_len_q[$];
    logic [7:0]    obs_opts_q[$];
    logic [DW-1:0] obs_data_q[$];
    logic          obs_ok;
    logic [CW-1:0] obs_err;
    logic          timeout;
    logic          hold_bad;

    // Expected values, filled by each scenario
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_q[$];

    smi_mem_write_burst_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                 (clk),
        .srst                (srst),
        .testParamsValid     (testParamsValid),
        .testParamBurstAddr  (testParamBurstAddr),
        .testParamBurstLen   (testParamBurstLen),
        .testParamBurstCount (testParamBurstCount),
        .testParamAddrStride (testParamAddrStride),
        .testParamBurstOpts  (testParamBurstOpts),
        .testParamDataInit   (testParamDataInit),
        .testParamDataIncr   (testParamDataIncr),
        .testParamsStop      (testParamsStop),
        .testDoneValid       (testDoneValid),
        .testDoneStatusOk    (testDoneStatusOk),
        .testDoneErrorCount  (testDoneErrorCount),
        .testDoneStop        (testDoneStop),
        .writeParamsValid    (writeParamsValid),
        .writeParamBurstAddr (writeParamBurstAddr),
        .writeParamBurstLen  (writeParamBurstLen),
        .writeParamBurstOpts (writeParamBurstOpts),
        .writeParamsStop     (writeParamsStop),
        .writeDataValid      (writeDataValid),
        .writeDataValue      (writeDataValue),
        .writeDataStop       (writeDataStop),
        .writeDoneValid      (writeDoneValid),
        .writeDoneStatusOk   (writeDoneStatusOk),
        .writeDoneStop       (writeDoneStop),
        .o_dbg_state         (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic drive_idle();
        testParamsValid     = 1'b0;
        testParamBurstAddr  = '0;
        testParamBurstLen   = '0;
        testParamBurstCount = '0;
        testParamAddrStride = '0;
        testParamBurstOpts  = '0;
        testParamDataInit   = '0;
        testParamDataIncr   = '0;
        testDoneStop        = 1'b0;
        writeParamsStop     = 1'b0;
        writeDataStop       = 1'b0;
        writeDoneValid      = 1'b0;
        writeDoneStatusOk   = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Issues one request and plays the controller and harness until the
    // result is accepted. st_bits[i] is the status returned for burst i.
    task automatic run_seq(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [CW-1:0] count, input logic [AW-1:0] stride,
                           input logic [7:0] opts, input logic [DW-1:0] init,
                           input logic [DW-1:0] incr, input logic [15:0] st_bits,
                           input bit bp);
        int  done_idx = 0;
        bit  got_done = 0;
        bit  held     = 0;
        logic          held_ok;
        logic [CW-1:0] held_err;
        obs_addr_q.delete(); obs_len_q.delete(); obs_opts_q.delete(); obs_data_q.delete();
        obs_ok = 1'bx; obs_err = 'x; timeout = 1'b0; hold_bad = 1'b0;
        held_ok = 1'b0; held_err = '0;

        @(negedge clk);
        testParamBurstAddr  = addr;
        testParamBurstLen   = len;
        testParamBurstCount = count;
        testParamAddrStride = stride;
        testParamBurstOpts  = opts;
        testParamDataInit   = init;
        testParamDataIncr   = incr;
        testParamsValid     = 1'b1;
        for (int w = 0; w < 50 && testParamsStop; w++) @(negedge clk);
        @(negedge clk);
        testParamsValid = 1'b0;

        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            writeParamsStop   = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            writeDataStop     = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            testDoneStop      = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            writeDoneValid    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            writeDoneStatusOk = (done_idx < 16) ? st_bits[done_idx] : 1'b1;

            if (held && (!testDoneValid || testDoneStatusOk !== held_ok ||
                         testDoneErrorCount !== held_err))
                hold_bad = 1'b1;
            held = 0;

            if (writeParamsValid && !writeParamsStop) begin
                obs_addr_q.push_back(writeParamBurstAddr);
                obs_len_q.push_back(writeParamBurstLen);
                obs_opts_q.push_back(writeParamBurstOpts);
            end
            if (writeDataValid && !writeDataStop)
                obs_data_q.push_back(writeDataValue);
            if (writeDoneValid && !writeDoneStop)
                done_idx++;
            if (testDoneValid) begin
                if (testDoneStop) begin
                    held     = 1;
                    held_ok  = testDoneStatusOk;
                    held_err = testDoneErrorCount;
                end else begin
                    obs_ok   = testDoneStatusOk;
                    obs_err  = testDoneErrorCount;
                    got_done = 1;
                end
            end
            @(negedge clk);
        end
        if (!got_done) timeout = 1'b1;
        drive_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (testParamsStop !== 1'b0) begin fail_cnt++; $display("FAIL reset_testParamsStop got %b want 0", testParamsStop); end
        tests_run++;
        if (testDoneValid !== 1'b0) begin fail_cnt++; $display("FAIL reset_testDoneValid got %b want 0", testDoneValid); end
        tests_run++;
        if (writeParamsValid !== 1'b0) begin fail_cnt++; $display("FAIL reset_writeParamsValid got %b want 0", writeParamsValid); end
        tests_run++;
        if (writeDataValid !== 1'b0) begin fail_cnt++; $display("FAIL reset_writeDataValid got %b want 0", writeDataValid); end
        tests_run++;
        if (writeDoneStop !== 1'b1) begin fail_cnt++; $display("FAIL reset_writeDoneStop got %b want 1", writeDoneStop); end
        tests_run++;
        if (o_dbg_state !== 3'd0) begin fail_cnt++; $display("FAIL reset_state got %0d want 0", o_dbg_state); end
        srst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_addr_q = '{32'h1000};
        exp_q      = '{32'd0, 32'd1, 32'd2, 32'd3};
        run_seq(32'h1000, 16'd4, 8'd1, 32'h0, 8'h5A, 32'd0, 32'd1, 16'hFFFF, 1'b0);
        tests_run++;
        if (timeout !== 1'b0) begin fail_cnt++; $display("FAIL single_timeout got %b want 0", timeout); end
        tests_run++;
        if (obs_addr_q.size() != exp_addr_q.size()) begin fail_cnt++; $display("FAIL single_param_count got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
        else foreach (exp_addr_q[i]) begin
            tests_run++;
            if (obs_addr_q[i] !== exp_addr_q[i] || obs_len_q[i] !== 16'd4 || obs_opts_q[i] !== 8'h5A) begin
                fail_cnt++; $display("FAIL single_params[%0d] got %h/%0d/%h want %h/4/5a", i, obs_addr_q[i], obs_len_q[i], obs_opts_q[i], exp_addr_q[i]);
            end
        end
        tests_run++;
        if (obs_data_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL single_word_count got %0d want %0d", obs_data_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_data_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL single_data[%0d] got %h want %h", i, obs_data_q[i], exp_q[i]); end
        end
        tests_run++;
        if (obs_ok !== 1'b1 || obs_err !== 8'd0) begin fail_cnt++; $display("FAIL single_result got ok=%b err=%0d want ok=1 err=0", obs_ok, obs_err); end
    endtask

    task automatic test_stride();
        exp_addr_q = '{32'h1000, 32'h1100, 32'h1200};
        exp_q      = '{32'd10, 32'd15, 32'd20, 32'd25, 32'd30, 32'd35};
        run_seq(32'h1000, 16'd2, 8'd3, 32'h100, 8'h00, 32'd10, 32'd5, 16'hFFFF, 1'b0);
        tests_run++;
        if (timeout !== 1'b0) begin fail_cnt++; $display("FAIL stride_timeout got %b want 0", timeout); end
        tests_run++;
        if (obs_addr_q.size() != exp_addr_q.size()) begin fail_cnt++; $display("FAIL stride_param_count got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
        else foreach (exp_addr_q[i]) begin
            tests_run++;
            if (obs_addr_q[i] !== exp_addr_q[i]) begin fail_cnt++; $display("FAIL stride_addr[%0d] got %h want %h", i, obs_addr_q[i], exp_addr_q[i]); end
        end
        tests_run++;
        if (obs_data_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL stride_word_count got %0d want %0d", obs_data_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_data_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL stride_data[%0d] got %0d want %0d", i, obs_data_q[i], exp_q[i]); end
        end
        tests_run++;
        if (obs_ok !== 1'b1 || obs_err !== 8'd0) begin fail_cnt++; $display("FAIL stride_result got ok=%b err=%0d want ok=1 err=0", obs_ok, obs_err); end
    endtask

    // Statuses OK,fail,OK,fail; the address also wraps past 2^32.
    task automatic test_errors();
        exp_addr_q = '{32'hFFFF_FF00, 32'hFFFF_FF80, 32'h0000_0000, 32'h0000_0080};
        run_seq(32'hFFFF_FF00, 16'd1, 8'd4, 32'h80, 8'h00, 32'd0, 32'd1, 16'b0101, 1'b0);
        tests_run++;
        if (timeout !== 1'b0) begin fail_cnt++; $display("FAIL errors_timeout got %b want 0", timeout); end
        tests_run++;
        if (obs_addr_q.size() != exp_addr_q.size()) begin fail_cnt++; $display("FAIL errors_param_count got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
        else foreach (exp_addr_q[i]) begin
            tests_run++;
            if (obs_addr_q[i] !== exp_addr_q[i]) begin fail_cnt++; $display("FAIL errors_addr[%0d] got %h want %h", i, obs_addr_q[i], exp_addr_q[i]); end
        end
        tests_run++;
        if (obs_ok !== 1'b0 || obs_err !== 8'd2) begin fail_cnt++; $display("FAIL errors_result got ok=%b err=%0d want ok=0 err=2", obs_ok, obs_err); end
    endtask

    // Random stops everywhere: 3 bursts x 5 words, data 100,103,...,142.
    task automatic test_backpressure();
        exp_addr_q = '{32'h2000, 32'h2040, 32'h2080};
        exp_q.delete();
        for (int k = 0; k < 15; k++) exp_q.push_back(32'd100 + 32'(3 * k));
        run_seq(32'h2000, 16'd5, 8'd3, 32'h40, 8'h00, 32'd100, 32'd3, 16'hFFFF, 1'b1);
        tests_run++;
        if (timeout !== 1'b0) begin fail_cnt++; $display("FAIL bp_timeout got %b want 0", timeout); end
        tests_run++;
        if (obs_addr_q.size() != exp_addr_q.size()) begin fail_cnt++; $display("FAIL bp_param_count got %0d want %0d", obs_addr_q.size(), exp_addr_q.size()); end
        else foreach (exp_addr_q[i]) begin
            tests_run++;
            if (obs_addr_q[i] !== exp_addr_q[i]) begin fail_cnt++; $display("FAIL bp_addr[%0d] got %h want %h", i, obs_addr_q[i], exp_addr_q[i]); end
        end
        tests_run++;
        if (obs_data_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL bp_word_count got %0d want %0d", obs_data_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_data_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL bp_data[%0d] got %0d want %0d", i, obs_data_q[i], exp_q[i]); end
        end
        tests_run++;
        if (hold_bad !== 1'b0) begin fail_cnt++; $display("FAIL bp_result_hold got %b want 0", hold_bad); end
        tests_run++;
        if (obs_ok !== 1'b1 || obs_err !== 8'd0) begin fail_cnt++; $display("FAIL bp_result got ok=%b err=%0d want ok=1 err=0", obs_ok, obs_err); end
    endtask

    task automatic test_wrap();
        exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        run_seq(32'h0, 16'd3, 8'd1, 32'h0, 8'h00, 32'hFFFF_FFFE, 32'd1, 16'hFFFF, 1'b0);
        tests_run++;
        if (obs_data_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL wrap_word_count got %0d want %0d", obs_data_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_data_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL wrap_data[%0d] got %h want %h", i, obs_data_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero();
        run_seq(32'h5000, 16'd4, 8'd0, 32'h10, 8'h00, 32'd0, 32'd1, 16'hFFFF, 1'b0);
        tests_run++;
        if (timeout !== 1'b0 || obs_addr_q.size() != 0 || obs_data_q.size() != 0) begin
            fail_cnt++; $display("FAIL zero_count_handshakes got params=%0d words=%0d timeout=%b want 0/0/0", obs_addr_q.size(), obs_data_q.size(), timeout);
        end
        tests_run++;
        if (obs_ok !== 1'b1 || obs_err !== 8'd0) begin fail_cnt++; $display("FAIL zero_count_result got ok=%b err=%0d want ok=1 err=0", obs_ok, obs_err); end
        run_seq(32'h5000, 16'd0, 8'd2, 32'h10, 8'h00, 32'd0, 32'd1, 16'h0000, 1'b0);
        tests_run++;
        if (timeout !== 1'b0 || obs_addr_q.size() != 0 || obs_data_q.size() != 0) begin
            fail_cnt++; $display("FAIL zero_len_handshakes got params=%0d words=%0d timeout=%b want 0/0/0", obs_addr_q.size(), obs_data_q.size(), timeout);
        end
        tests_run++;
        if (obs_ok !== 1'b1 || obs_err !== 8'd0) begin fail_cnt++; $display("FAIL zero_len_result got ok=%b err=%0d want ok=1 err=0", obs_ok, obs_err); end
    endtask

    // Latency of the first handshakes, then reset in the middle of WriteData.
    task automatic test_reset_mid();
        @(negedge clk);
        testParamBurstAddr  = 32'h3000;
        testParamBurstLen   = 16'd8;
        testParamBurstCount = 8'd2;
        testParamAddrStride = 32'h0;
        testParamBurstOpts  = 8'h00;
        testParamDataInit   = 32'd7;
        testParamDataIncr   = 32'd2;
        testParamsValid     = 1'b1;
        @(negedge clk);
        testParamsValid = 1'b0;
        tests_run++;
        if (writeParamsValid !== 1'b1) begin fail_cnt++; $display("FAIL mid_param_latency got %b want 1", writeParamsValid); end
        @(negedge clk);
        tests_run++;
        if (writeDataValid !== 1'b1 || writeDataValue !== 32'd7) begin
            fail_cnt++; $display("FAIL mid_first_word got v=%b d=%0d want v=1 d=7", writeDataValid, writeDataValue);
        end
        @(negedge clk);
        tests_run++;
        if (writeDataValue !== 32'd9) begin fail_cnt++; $display("FAIL mid_second_word got %0d want 9", writeDataValue); end
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        tests_run++;
        if (writeDataValid !== 1'b0 || testParamsStop !== 1'b0 || writeParamsValid !== 1'b0) begin
            fail_cnt++; $display("FAIL mid_after_reset got dv=%b ps=%b pv=%b want 0/0/0", writeDataValid, testParamsStop, writeParamsValid);
        end
        exp_q = '{32'h55, 32'h66};
        run_seq(32'h4000, 16'd2, 8'd1, 32'h0, 8'h00, 32'h55, 32'h11, 16'hFFFF, 1'b0);
        tests_run++;
        if (obs_addr_q.size() != 1 || obs_data_q.size() != 2) begin
            fail_cnt++; $display("FAIL mid_rerun_counts got params=%0d words=%0d want 1/2", obs_addr_q.size(), obs_data_q.size());
        end else begin
            tests_run++;
            if (obs_addr_q[0] !== 32'h4000 || obs_data_q[0] !== exp_q[0] || obs_data_q[1] !== exp_q[1]) begin
                fail_cnt++; $display("FAIL mid_rerun_values got %h %h %h want 4000 55 66", obs_addr_q[0], obs_data_q[0], obs_data_q[1]);
            end
        end
        tests_run++;
        if (obs_ok !== 1'b1 || obs_err !== 8'd0) begin fail_cnt++; $display("FAIL mid_rerun_result got ok=%b err=%0d want ok=1 err=0", obs_ok, obs_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stride();
        test_errors();
        test_backpressure();
        test_wrap();
        test_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
